program_sequencer: RTL

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/program_sequencer.sv
// Program-mode sequencer: buffers register-write commands and replays them into the
// shape register file while the renderer is stalled between frames.
module program_sequencer #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [10:0] cmd_shape,
    input  logic [11:0] cmd_reg,
    input  logic [11:0] cmd_data,
    output logic        cmd_ready,
    input  logic        render_idle,
    input  logic        resume,
    output logic        program_out,
    output logic        wr_en,
    output logic [10:0] x_out,
    output logic [11:0] y_out,
    output logic [11:0] data_out,
    input  logic        wr_ack,
    output logic        overflow
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] OneCount  = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);

    typedef enum logic [1:0] {
        StRun,
        StWaitIdle,
        StWrite,
        StHold
    } state_e;

    // Entry layout: {shape[34:24], reg[23:12], data[11:0]}
    logic [34:0]     r_mem [FIFO_DEPTH];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;
    logic            r_overflow;
    logic            r_resume_q;
    state_e          r_state;
    state_e          w_state_next;

    logic            w_push;
    logic            w_pop;
    logic            w_resume_rise;
    logic            w_wr_en;
    logic            w_program;
    logic [34:0]     w_head;

    assign cmd_ready     = (r_count != FullCount);
    assign w_push        = cmd_valid && cmd_ready;
    assign w_pop         = w_wr_en && wr_ack;
    assign w_resume_rise = resume && !r_resume_q;
    assign w_head        = r_mem[r_rptr];

    // Command storage; contents need no reset because outputs are gated by wr_en.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_shape, cmd_reg, cmd_data};
        end
    end

    // FIFO pointers and occupancy; push and pop may both happen in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PtrOne;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrOne;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + OneCount;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - OneCount;
            end
        end
    end

    // Sticky drop flag and resume edge history.
    // History resets high so a resume held across reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_resume_q <= 1'b1;
        end else begin
            r_resume_q <= resume;
            if (cmd_valid && !cmd_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_program    = 1'b0;
        unique case (r_state)
            StRun: begin
                if (r_count != '0) begin
                    w_state_next = StWaitIdle;
                end
            end
            StWaitIdle: begin
                w_program = 1'b1;
                if (render_idle) begin
                    w_state_next = StWrite;
                end
            end
            StWrite: begin
                w_program = 1'b1;
                w_wr_en   = 1'b1;
                if (wr_ack && (r_count == OneCount) && !w_push) begin
                    w_state_next = StHold;
                end
            end
            StHold: begin
                w_program = 1'b1;
                // A push landing with the resume edge keeps the stall so program_out
                // never drops while the FIFO holds data.
                if (r_count != '0) begin
                    w_state_next = StWrite;
                end else if (w_resume_rise && !w_push) begin
                    w_state_next = StRun;
                end
            end
            default: begin
                w_state_next = StRun;
            end
        endcase
    end

    assign program_out = w_program;
    assign wr_en       = w_wr_en;
    assign x_out       = w_wr_en ? w_head[34:24] : '0;
    assign y_out       = w_wr_en ? w_head[23:12] : '0;
    assign data_out    = w_wr_en ? w_head[11:0]  : '0;
    assign overflow    = r_overflow;

endmodule
